// File: rtl/host_rx_arbiter_pkg.sv
// Shared types and helpers for the host receive arbiter slice (package host_rx_pkg).
package host_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XMIT = 2'b01,
    DROP = 2'b10
  } state_e;

  localparam int unsigned DEF_CH_NUM      = 4;
  localparam int unsigned DEF_DATA_W      = 9;
  localparam int unsigned DEF_TIMER_W     = 19;
  localparam int unsigned DEF_MAX_PKT_LEN = 2047;
  localparam int unsigned DEF_CH_W        = 3;

  function automatic int unsigned flag_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

  function automatic int unsigned ctrl_w(input int unsigned ch_w, input int unsigned timer_w);
    return ch_w + timer_w;
  endfunction

endpackage

// File: rtl/host_rx_arbiter_rr.sv
// Round-robin priority scan: first requester at or after ptr_i (mod N) wins.
module rr_arbiter_n #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             gnt_vld_o,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  always_comb begin
    int unsigned c;
    logic        found;
    c         = 0;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr_i) + k) % N;
      if (!found && req_i[c]) begin
        found       = 1'b1;
        gnt_oh_o[c] = 1'b1;
        gnt_idx_o   = IDX_W'(c);
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/host_rx_arbiter.sv
// N-channel host receive front end: packet round-robin, head stamping, length limit.
// Optional per-channel packet counters: define HOST_RX_ARB_PKT_CNT_EN.
module host_rx_arbiter
  import host_rx_pkg::*;
#(
  parameter int unsigned CH_NUM      = DEF_CH_NUM,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMER_W     = DEF_TIMER_W,
  parameter int unsigned MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  parameter int unsigned CH_W        = DEF_CH_W
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [1:0]                iv_cfg_finish,
  input  logic [CH_NUM*DATA_W-1:0]  iv_data,
  output logic [CH_NUM-1:0]         ov_data_rd,
  input  logic [CH_NUM-1:0]         iv_data_empty,
  input  logic [TIMER_W-1:0]        iv_timer,
  output logic [DATA_W-1:0]         ov_data,
  output logic                      o_data_wr,
  output logic [CH_W+TIMER_W-1:0]   ov_ctrl_data,
  output logic [1:0]                ov_state,
  output logic                      o_discard_pulse,
  output logic                      o_trunc_pulse,
  output logic [CH_NUM*16-1:0]      ov_pkt_cnt
);

  localparam int unsigned FLAG   = flag_bit(DATA_W);
  localparam int unsigned CTRL_W = ctrl_w(CH_W, TIMER_W);
  localparam int unsigned LEN_W  = $clog2(MAX_PKT_LEN + 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     rr_q, rr_d, ch_q, ch_d;
  logic [LEN_W-1:0]    len_q, len_d, len_inc;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d, disc_q, disc_d, trunc_q, trunc_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;

  logic                gnt_vld;
  logic [CH_NUM-1:0]   gnt_oh, sel_oh;
  logic [CH_W-1:0]     gnt_idx, sel;
  logic                sel_empty, pop, flag;
  logic [DATA_W-1:0]   sel_byte;

  rr_arbiter_n #(
    .N     (CH_NUM),
    .IDX_W (CH_W)
  ) u_rr (
    .req_i     (~iv_data_empty),
    .ptr_i     (rr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  assign sel = (state_q == IDLE) ? gnt_idx : ch_q;

  always_comb begin
    sel_empty = 1'b1;
    sel_byte  = '0;
    sel_oh    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (CH_W'(i) == sel) begin
        sel_empty = iv_data_empty[i];
        sel_byte  = iv_data[i*DATA_W +: DATA_W];
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Pop is gated by reset_n so no FIFO is drained while the block is held in reset.
  assign pop        = reset_n && ((state_q == IDLE) ? gnt_vld : !sel_empty);
  assign ov_data_rd = pop ? ((state_q == IDLE) ? gnt_oh : sel_oh) : '0;
  assign flag       = sel_byte[FLAG];
  assign len_inc    = len_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    len_d   = len_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    ctrl_d  = ctrl_q;
    disc_d  = 1'b0;
    trunc_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          rr_d = (gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
          ch_d = gnt_idx;
          if (!flag) begin
            disc_d = 1'b1;
          end else if (iv_cfg_finish == 2'b00) begin
            disc_d  = 1'b1;
            state_d = DROP;
          end else begin
            state_d = XMIT;
            wr_d    = 1'b1;
            data_d  = sel_byte;
            ctrl_d  = {gnt_idx, iv_timer};
            len_d   = LEN_W'(1);
          end
        end
      end
      XMIT: begin
        if (pop) begin
          wr_d   = 1'b1;
          data_d = sel_byte;
          len_d  = len_inc;
          if (flag) begin
            state_d = IDLE;
          end else if (len_inc == LEN_W'(MAX_PKT_LEN)) begin
            data_d[FLAG] = 1'b1;
            trunc_d      = 1'b1;
            state_d      = DROP;
          end
        end
      end
      DROP: begin
        if (pop && flag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      len_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
      disc_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      disc_q  <= disc_d;
      trunc_q <= trunc_d;
    end
  end

  assign ov_data         = data_q;
  assign o_data_wr       = wr_q;
  assign ov_ctrl_data    = ctrl_q;
  assign ov_state        = state_q;
  assign o_discard_pulse = disc_q;
  assign o_trunc_pulse   = trunc_q;

`ifdef HOST_RX_ARB_PKT_CNT_EN
  logic        tail_fwd;
  logic [15:0] cnt_q [CH_NUM];

  // Any forwarded byte that leaves XMIT is a tail, forced or natural.
  assign tail_fwd = (state_q == XMIT) && pop && (state_d != XMIT);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
    end else if (tail_fwd) begin
      cnt_q[ch_q] <= cnt_q[ch_q] + 16'd1;
    end
  end

  always_comb begin
    ov_pkt_cnt = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) ov_pkt_cnt[i*16 +: 16] = cnt_q[i];
  end
`else
  assign ov_pkt_cnt = '0;
`endif

endmodule
